// File: rtl/map_port_arbiter.sv
// Tile-map RAM game-logic port arbiter: Pac-Man (read/write) vs ghost AI (read-only), round-robin on ties.
// Latency: grant edge E -> RAM strobe E..E+1 -> ack pulse registered at E+2; next grant earliest at E+4.
// Backpressure: requesters hold req until their one-cycle ack; a req arriving while busy waits in place.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   pac_req/we/x/y/wdata      Pac-Man request; pac_ack/pac_rdata completion and read result
//   gh_req/x/y                ghost read request; gh_ack/gh_rdata completion and read result
//   ram_addr/wr/rd/din        registered RAM port drive; ram_dout read data (valid after the strobe edge)
//   busy                      high whenever an access is in flight
module map_port_arbiter #(
  parameter int         COLS     = 40,
  parameter int         ROWS     = 30,
  parameter logic [2:0] OOB_TILE = 3'b001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pac_req,
  input  logic        pac_we,
  input  logic [5:0]  pac_x,
  input  logic [4:0]  pac_y,
  input  logic [2:0]  pac_wdata,
  output logic        pac_ack,
  output logic [2:0]  pac_rdata,
  input  logic        gh_req,
  input  logic [5:0]  gh_x,
  input  logic [4:0]  gh_y,
  output logic        gh_ack,
  output logic [2:0]  gh_rdata,
  output logic [10:0] ram_addr,
  output logic        ram_wr,
  output logic        ram_rd,
  output logic [2:0]  ram_din,
  input  logic [2:0]  ram_dout,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_ACK} state_t;

  localparam logic [6:0]  LP_COLS   = 7'(COLS);
  localparam logic [5:0]  LP_ROWS   = 6'(ROWS);
  localparam logic [10:0] LP_COLS_A = 11'(COLS);

  state_t      r_state;
  logic        r_pac_prio;   // 1: Pac-Man wins the next tie
  logic        r_gnt_gh;     // granted requester of the access in flight
  logic        r_we;
  logic        r_oob;
  logic [10:0] r_ram_addr;
  logic        r_ram_wr;
  logic        r_ram_rd;
  logic [2:0]  r_ram_din;
  logic        r_pac_ack;
  logic        r_gh_ack;
  logic [2:0]  r_pac_rdata;
  logic [2:0]  r_gh_rdata;
  logic        r_busy;

  logic        w_any;
  logic        w_gnt_gh;
  logic        w_we;
  logic        w_oob;
  logic [5:0]  w_x;
  logic [4:0]  w_y;
  logic [10:0] w_addr;

  // Ghost wins when it is the only requester, or on a tie when Pac-Man went last.
  assign w_any    = pac_req | gh_req;
  assign w_gnt_gh = gh_req & (~pac_req | ~r_pac_prio);
  assign w_x      = w_gnt_gh ? gh_x : pac_x;
  assign w_y      = w_gnt_gh ? gh_y : pac_y;
  assign w_we     = ~w_gnt_gh & pac_we;
  assign w_addr   = ({6'd0, w_y} * LP_COLS_A) + {5'd0, w_x};
  assign w_oob    = ({1'b0, w_x} >= LP_COLS) | ({1'b0, w_y} >= LP_ROWS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pac_prio  <= 1'b1;
      r_gnt_gh    <= 1'b0;
      r_we        <= 1'b0;
      r_oob       <= 1'b0;
      r_ram_addr  <= 11'd0;
      r_ram_wr    <= 1'b0;
      r_ram_rd    <= 1'b0;
      r_ram_din   <= 3'd0;
      r_pac_ack   <= 1'b0;
      r_gh_ack    <= 1'b0;
      r_pac_rdata <= 3'd0;
      r_gh_rdata  <= 3'd0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt_gh   <= w_gnt_gh;
            r_we       <= w_we;
            r_oob      <= w_oob;
            r_pac_prio <= w_gnt_gh;
            r_busy     <= 1'b1;
            r_state    <= S_ACCESS;
            // Out-of-range accesses never reach the RAM; the address register keeps its old value.
            if (!w_oob) begin
              r_ram_addr <= w_addr;
              r_ram_wr   <= w_we;
              r_ram_rd   <= ~w_we;
              if (w_we) r_ram_din <= pac_wdata;
            end
          end
        end
        S_ACCESS: begin
          r_ram_wr <= 1'b0;
          r_ram_rd <= 1'b0;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          if (!r_we) begin
            if (r_gnt_gh) r_gh_rdata  <= r_oob ? OOB_TILE : ram_dout;
            else          r_pac_rdata <= r_oob ? OOB_TILE : ram_dout;
          end
          r_gh_ack  <= r_gnt_gh;
          r_pac_ack <= ~r_gnt_gh;
          r_state   <= S_ACK;
        end
        S_ACK: begin
          // Requests are ignored here so a requester dropping req on its ack is not re-granted.
          r_gh_ack  <= 1'b0;
          r_pac_ack <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ram_addr  = r_ram_addr;
  assign ram_wr    = r_ram_wr;
  assign ram_rd    = r_ram_rd;
  assign ram_din   = r_ram_din;
  assign pac_ack   = r_pac_ack;
  assign gh_ack    = r_gh_ack;
  assign pac_rdata = r_pac_rdata;
  assign gh_rdata  = r_gh_rdata;
  assign busy      = r_busy;

endmodule
